// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: shifts words through a two-phase latch chain
// with non-overlapping master/slave pulses and a valid/ready host port.
package TopPkg;
  typedef struct packed {
    logic clk_master;
    logic clk_slave;
    logic reset;
    logic enable;
    logic update;
  } ScanControl;
endpackage

module scan_chain_ctrl
  import TopPkg::*;
#(
  parameter int WORD_WIDTH   = 32,
  parameter int PHASE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1,
  parameter int LEN_W        = $clog2(WORD_WIDTH+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [WORD_WIDTH-1:0] cmd_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WORD_WIDTH-1:0] resp_data,
  output ScanControl            scan_ctrl,
  output logic                  scan_in,
  input  logic                  scan_out
);

  localparam logic [1:0] OP_SHIFT = 2'd0;
  localparam logic [1:0] OP_SHUPD = 2'd1;
  localparam logic [1:0] OP_RST   = 2'd2;

  localparam int TW = $clog2(PHASE_CYCLES+GAP_CYCLES+1);
  localparam logic [TW-1:0] P_LAST = TW'(PHASE_CYCLES-1);
  localparam logic [TW-1:0] G_LAST = TW'(GAP_CYCLES-1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WORD_WIDTH);

  typedef enum logic [3:0] {
    IDLE, MASTER, GAP_M, SLAVE, GAP_S,
    UPD, GAP_U, RST, GAP_R, RESP
  } state_t;

  state_t                state, state_n;
  logic [TW-1:0]         tmr, tmr_n;
  logic [1:0]            op_q, op_n;
  logic [LEN_W-1:0]      len_q, len_n, lenc;
  logic [LEN_W-1:0]      bit_q, bit_n;
  logic [WORD_WIDTH-1:0] shift_q, shift_n;
  logic [WORD_WIDTH-1:0] cap_q, cap_n;
  logic                  p_last, g_last;
  logic                  in_shift;
  ScanControl            ctrl_n;

  assign lenc   = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
  assign p_last = (tmr == P_LAST);
  assign g_last = (tmr == G_LAST);

  always_comb begin
    state_n = state;
    tmr_n   = tmr + 1'b1;
    op_n    = op_q;
    len_n   = len_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    cap_n   = cap_q;
    unique case (state)
      IDLE: begin
        tmr_n = '0;
        if (cmd_valid) begin
          op_n    = cmd_op;
          len_n   = lenc;
          shift_n = cmd_data;
          cap_n   = '0;
          bit_n   = '0;
          unique case (cmd_op)
            OP_SHIFT: state_n = (lenc == '0) ? RESP : MASTER;
            OP_SHUPD: state_n = (lenc == '0) ? UPD : MASTER;
            OP_RST:   state_n = RST;
            default:  state_n = UPD;
          endcase
        end
      end
      MASTER: if (p_last) begin
        // Tail still shows the old bit: the slave has not pulsed yet.
        for (int i = 0; i < WORD_WIDTH; i++)
          if (bit_q == LEN_W'(i)) cap_n[i] = scan_out;
        state_n = GAP_M;
        tmr_n   = '0;
      end
      GAP_M: if (g_last) begin
        state_n = SLAVE;
        tmr_n   = '0;
      end
      SLAVE: if (p_last) begin
        state_n = GAP_S;
        tmr_n   = '0;
      end
      GAP_S: if (g_last) begin
        shift_n = shift_q >> 1;
        bit_n   = bit_q + 1'b1;
        tmr_n   = '0;
        if (bit_n == len_q)
          state_n = (op_q == OP_SHUPD) ? UPD : RESP;
        else
          state_n = MASTER;
      end
      UPD: if (p_last) begin
        state_n = GAP_U;
        tmr_n   = '0;
      end
      GAP_U: if (g_last) begin
        state_n = RESP;
        tmr_n   = '0;
      end
      RST: if (p_last) begin
        state_n = GAP_R;
        tmr_n   = '0;
      end
      GAP_R: if (g_last) begin
        state_n = RESP;
        tmr_n   = '0;
      end
      RESP: begin
        tmr_n = '0;
        if (resp_ready) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        tmr_n   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered.
  always_comb begin
    in_shift = (state_n == MASTER) || (state_n == GAP_M) ||
               (state_n == SLAVE)  || (state_n == GAP_S);
    ctrl_n            = '0;
    ctrl_n.clk_master = (state_n == MASTER);
    ctrl_n.clk_slave  = (state_n == SLAVE);
    ctrl_n.update     = (state_n == UPD);
    ctrl_n.reset      = (state_n == RST);
    ctrl_n.enable     = in_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tmr        <= '0;
      op_q       <= '0;
      len_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      cap_q      <= '0;
      scan_ctrl  <= '0;
      scan_in    <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      cmd_ready  <= 1'b1;
    end else begin
      state      <= state_n;
      tmr        <= tmr_n;
      op_q       <= op_n;
      len_q      <= len_n;
      bit_q      <= bit_n;
      shift_q    <= shift_n;
      cap_q      <= cap_n;
      scan_ctrl  <= ctrl_n;
      scan_in    <= in_shift & shift_n[0];
      resp_valid <= (state_n == RESP);
      resp_data  <= (state_n == RESP) ? cap_n : '0;
      cmd_ready  <= (state_n == IDLE);
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: 4-cell latch chain model, response
// scoreboard and a pulse non-overlap monitor.
module tb_scan_chain_ctrl;
  import TopPkg::*;

  localparam int W = 8;
  localparam int LW = $clog2(W+1);
  localparam int L = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [W-1:0]  cmd_data = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [W-1:0]  resp_data;
  ScanControl    scan_ctrl;
  logic          scan_in;
  logic          scan_out;

  scan_chain_ctrl #(
    .WORD_WIDTH(W), .PHASE_CYCLES(2), .GAP_CYCLES(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data),
    .scan_ctrl(scan_ctrl), .scan_in(scan_in), .scan_out(scan_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Two-phase latch chain: master loads from upstream slave.
  logic [L-1:0] mcell = '0, scell = '0;
  logic         load = 1'b0;
  logic [L-1:0] load_val = '0;
  assign scan_out = scell[L-1];

  always @(posedge clk) begin
    if (load) begin
      scell <= load_val;
    end else if (scan_ctrl.reset) begin
      mcell <= '0;
      scell <= '0;
    end else begin
      if (scan_ctrl.clk_master) mcell <= {scell[L-2:0], scan_in};
      if (scan_ctrl.clk_slave)  scell <= mcell;
    end
  end

  int cyc = 0, en_cnt = 0, upd_cnt = 0, rst_cnt = 0, mst_cnt = 0;
  int last_en = 0, upd_start = 0, run = 0;
  logic [3:0] pul, prev = '0;

  always @(negedge clk) begin
    cyc++;
    pul = {scan_ctrl.clk_master, scan_ctrl.clk_slave,
           scan_ctrl.update, scan_ctrl.reset};
    if (!rst_n) begin
      prev = '0;
      run  = 0;
    end else begin
      if (pul != 0) check("onehot", 32'($onehot(pul)), 1);
      if (pul != 0 && prev != 0) check("gap", 32'(pul), 32'(prev));
      if (pul != 0) run = (prev == 0) ? 1 : run + 1;
      else if (prev != 0) check("pulse_len", run, 2);
      if (scan_ctrl.enable) begin en_cnt++; last_en = cyc; end
      if (scan_ctrl.update) upd_cnt++;
      if (scan_ctrl.update && !prev[1]) upd_start = cyc;
      if (scan_ctrl.reset) rst_cnt++;
      if (scan_ctrl.clk_master) mst_cnt++;
      prev = pul;
    end
  end

  typedef struct { logic [W-1:0] data; int lat; } exp_t;
  exp_t sb[$];
  exp_t e;
  int b_en, b_upd, b_rst, b_mst;

  function automatic logic [W-1:0] exp_cap(logic [L-1:0] pre,
                                          logic [W-1:0] d, int n);
    logic [W-1:0] r = '0;
    for (int i = 0; i < n; i++)
      r[i] = (i < L) ? pre[L-1-i] : d[i-L];
    return r;
  endfunction

  function automatic logic [L-1:0] exp_chain(logic [W-1:0] d, int n);
    logic [L-1:0] c = '0;
    for (int j = 0; j < L; j++) c[j] = d[n-1-j];
    return c;
  endfunction

  task automatic preload(logic [L-1:0] v);
    load_val = v;
    load = 1'b1;
    @(posedge clk); #2;
    load = 1'b0;
  endtask

  task automatic run_cmd(logic [1:0] op, int len, logic [W-1:0] d,
                         logic [W-1:0] xd, int xl, int hold);
    int lat;
    logic [W-1:0] first;
    b_en = en_cnt; b_upd = upd_cnt; b_rst = rst_cnt; b_mst = mst_cnt;
    sb.push_back('{xd, xl});
    check("cmd_ready_pre", 32'(cmd_ready), 1);
    cmd_op = op; cmd_len = LW'(len); cmd_data = d;
    cmd_valid = 1'b1;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    cmd_data = ~d;
    lat = 1;
    while (!resp_valid && lat < 300) begin
      @(posedge clk); #2;
      lat++;
    end
    e = sb.pop_front();
    check("latency", lat, e.lat);
    check("resp_data", 32'(resp_data), 32'(e.data));
    first = resp_data;
    if (hold > 0) begin
      cmd_valid = 1'b1;
      cmd_op = 2'd2;
      repeat (hold) begin
        @(posedge clk); #2;
        check("hold_data", 32'(resp_data), 32'(first));
        check("hold_valid", 32'(resp_valid), 1);
        check("hold_ready", 32'(cmd_ready), 0);
      end
      cmd_valid = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk); #2;
    resp_ready = 1'b0;
    check("resp_drop", 32'(resp_valid), 0);
    check("cmd_ready_post", 32'(cmd_ready), 1);
  endtask

  initial begin
    int srise, guard, seen;
    logic ps;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ctrl", 32'(scan_ctrl), 0);
    check("rst_scan_in", 32'(scan_in), 0);
    check("rst_valid", 32'(resp_valid), 0);
    check("rst_data", 32'(resp_data), 0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    check("rst_cmd_ready", 32'(cmd_ready), 1);

    preload(4'b1010);
    run_cmd(2'd0, 4, 8'h05, 8'h05, 25, 0);
    check("shift_en", en_cnt - b_en, 24);
    check("shift_upd", upd_cnt - b_upd, 0);
    check("shift_chain", 32'(scell), 32'(4'b1010));

    preload(4'b1010);
    run_cmd(2'd1, 4, 8'h05, 8'h05, 28, 5);
    check("su_en", en_cnt - b_en, 24);
    check("su_upd", upd_cnt - b_upd, 2);
    check("su_upd_start", upd_start - last_en, 1);

    run_cmd(2'd0, 0, 8'hFF, 8'h00, 1, 0);
    check("len0_mst", mst_cnt - b_mst, 0);
    check("len0_en", en_cnt - b_en, 0);

    preload(4'b0110);
    run_cmd(2'd0, 15, 8'hA7, exp_cap(4'b0110, 8'hA7, 8), 49, 0);
    check("clamp_en", en_cnt - b_en, 48);
    check("clamp_mst", mst_cnt - b_mst, 16);
    check("clamp_chain", 32'(scell), 32'(exp_chain(8'hA7, 8)));

    run_cmd(2'd2, 4, 8'hFF, 8'h00, 4, 0);
    check("crst_pulse", rst_cnt - b_rst, 2);
    check("crst_chain", 32'(scell), 0);

    run_cmd(2'd3, 4, 8'hFF, 8'h00, 4, 0);
    check("upd_pulse", upd_cnt - b_upd, 2);
    check("upd_en", en_cnt - b_en, 0);

    run_cmd(2'd1, 0, 8'hFF, 8'h00, 4, 0);
    check("su0_upd", upd_cnt - b_upd, 2);

    preload(4'b1100);
    cmd_op = 2'd0; cmd_len = LW'(8); cmd_data = 8'h5A;
    cmd_valid = 1'b1;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    srise = 0; guard = 0; ps = 1'b0;
    while (srise < 3 && guard < 200) begin
      if (scan_ctrl.clk_slave && !ps) srise++;
      ps = scan_ctrl.clk_slave;
      if (srise < 3) begin @(posedge clk); #2; end
      guard++;
    end
    check("abort_reached", srise, 3);
    rst_n = 1'b0;
    #1;
    check("abort_ctrl", 32'(scan_ctrl), 0);
    check("abort_valid", 32'(resp_valid), 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    check("abort_cmd_ready", 32'(cmd_ready), 1);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #2;
      if (resp_valid) seen = 1;
    end
    check("abort_no_resp", seen, 0);

    preload(4'b0011);
    run_cmd(2'd0, 4, 8'h3C, exp_cap(4'b0011, 8'h3C, 4), 25, 0);
    check("recover_chain", 32'(scell), 32'(exp_chain(8'h3C, 4)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
